router_input_arbiter: RTL and testbench

- Shares the single router input port (packet_valid/datain, back-pressured by busy) among NUM_SRC packet sources.
- Grants whole packets only, round-robin, at packet boundaries.
- Tracks packet length from the header byte (datain[7:2]) so it knows when the parity byte is due.
- Inserts an inter-packet gap so the router can finish its parity check before the next header.

---
 rtl/router_input_arbiter.sv | 173 +++++++++++++++++
 tb/tb_router_input_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_arbiter.sv
// Round-robin, packet-granular arbiter sharing one router input port.
// Tracks header length to find the parity byte and enforces an inter-packet gap.
module router_input_arbiter #(
   parameter int NUM_SRC    = 3,
   parameter int GAP_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SRC-1:0]   src_req,
   input  logic [NUM_SRC-1:0]   src_valid,
   input  logic [8*NUM_SRC-1:0] src_data,
   output logic [NUM_SRC-1:0]   src_ready,
   input  logic [NUM_SRC-1:0]   err_clr,
   input  logic                 busy,
   output logic                 pkt_valid,
   output logic [7:0]           data_out,
   output logic [NUM_SRC-1:0]   grant,
   output logic [NUM_SRC-1:0]   proto_err,
   output logic                 pkt_done
);

   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;

   state_t               state_q, state_d;
   logic [NUM_SRC-1:0]   grant_q, grant_d;
   logic [NUM_SRC-1:0]   mask_q, mask_d;
   logic [NUM_SRC-1:0]   proto_err_q, proto_err_d;
   logic [IW-1:0]        gidx_q, gidx_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [5:0]           len_q, len_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic                 pkt_done_q, pkt_done_d;

   logic                 active, vld_g, acc, abort, found;
   logic [7:0]           byte_g;
   logic [NUM_SRC-1:0]   elig;
   logic [IW-1:0]        nxt_ptr, pick, cidx;
   logic [IW:0]          cand;

   assign active = (state_q == HEADER) || (state_q == PAYLOAD)
                || (state_q == PARITY);
   assign elig   = src_req & ~mask_q;
   assign acc    = active & (|grant_q) & vld_g & ~busy;
   assign abort  = active & ~busy & ~vld_g;

   assign nxt_ptr = (gidx_q == IW'(NUM_SRC - 1)) ? '0 : gidx_q + 1'b1;

   always_comb begin
      vld_g  = 1'b0;
      byte_g = 8'h00;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gidx_q == IW'(i)) begin
            vld_g  = src_valid[i];
            byte_g = src_data[i*8 +: 8];
         end
      end
   end

   // first eligible source at or after the pointer, wrapping
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      cidx  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(NUM_SRC))
            cand = cand - (IW+1)'(NUM_SRC);
         cidx = cand[IW-1:0];
         if (!found && elig[cidx]) begin
            found = 1'b1;
            pick  = cidx;
         end
      end
   end

   assign pkt_valid = ((state_q == HEADER) || (state_q == PAYLOAD)) & vld_g;
   assign data_out  = (active & vld_g) ? byte_g : 8'h00;
   assign src_ready = acc ? grant_q : '0;
   assign grant     = grant_q;
   assign proto_err = proto_err_q;
   assign pkt_done  = pkt_done_q;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      ptr_d       = ptr_q;
      len_d       = len_q;
      gap_d       = gap_q;
      pkt_done_d  = 1'b0;
      mask_d      = mask_q & src_req;
      proto_err_d = proto_err_q & ~err_clr;

      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               gidx_d        = pick;
               state_d       = HEADER;
            end
         end
         HEADER: begin
            if (acc) begin
               len_d   = byte_g[7:2];
               state_d = (byte_g[7:2] != 6'd0) ? PAYLOAD : PARITY;
            end
         end
         PAYLOAD: begin
            if (acc) begin
               len_d = len_q - 6'd1;
               if (len_q == 6'd1)
                  state_d = PARITY;
            end
         end
         PARITY: begin
            if (acc) begin
               pkt_done_d = 1'b1;
               ptr_d      = nxt_ptr;
               grant_d    = '0;
               gap_d      = '0;
               state_d    = GAP;
            end
         end
         GAP: begin
            if (gap_q == GW'(GAP_CYCLES - 1))
               state_d = IDLE;
            else
               gap_d = gap_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // a missing byte closes the packet; the router sees 0x00 as parity
      if (abort) begin
         proto_err_d[gidx_q] = 1'b1;
         mask_d[gidx_q]      = 1'b1;
         ptr_d               = nxt_ptr;
         grant_d             = '0;
         gap_d               = '0;
         state_d             = GAP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         gidx_q      <= '0;
         ptr_q       <= '0;
         len_q       <= '0;
         gap_q       <= '0;
         mask_q      <= '0;
         proto_err_q <= '0;
         pkt_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         gidx_q      <= gidx_d;
         ptr_q       <= ptr_d;
         len_q       <= len_d;
         gap_q       <= gap_d;
         mask_q      <= mask_d;
         proto_err_q <= proto_err_d;
         pkt_done_q  <= pkt_done_d;
      end
   end

endmodule

// File: tb/tb_router_input_arbiter.sv
// Directed bench for router_input_arbiter: a per-cycle vector table
// plus hand-written multi-cycle sequences driven by simple byte sources.
module tb_router_input_arbiter;

   localparam int N = 3;
   localparam int G = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   src_req, src_valid, src_ready, err_clr;
   logic [8*N-1:0] src_data;
   logic           busy, pkt_valid, pkt_done;
   logic [7:0]     data_out;
   logic [N-1:0]   grant, proto_err;

   router_input_arbiter #(.NUM_SRC(N), .GAP_CYCLES(G)) dut (
      .clk(clk), .rst(rst),
      .src_req(src_req), .src_valid(src_valid), .src_data(src_data),
      .src_ready(src_ready), .err_clr(err_clr), .busy(busy),
      .pkt_valid(pkt_valid), .data_out(data_out), .grant(grant),
      .proto_err(proto_err), .pkt_done(pkt_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] pk [0:N-1][0:15];
   int         plen [0:N-1];
   int         idx  [0:N-1];
   int         acc_cnt [0:N-1];
   logic [N-1:0] vmask, rq, ec;
   logic         rs;

   logic [N-1:0] o_grant, o_ready, o_perr;
   logic         o_pv, o_done;
   logic [7:0]   o_dout;

   typedef struct {
      logic [N-1:0]   req;
      logic [N-1:0]   valid;
      logic [8*N-1:0] data;
      logic [N-1:0]   e_grant;
      logic           e_pv;
      logic [7:0]     e_dout;
      logic [N-1:0]   e_ready;
      logic           e_done;
   } vec_t;

   vec_t tv [0:8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic int oh2i(input logic [N-1:0] oh);
      int r = -1;
      for (int i = 0; i < N; i++) if (oh[i]) r = i;
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1; src_req = '0; src_valid = '0; src_data = '0;
      err_clr = '0; busy = 1'b0;
      rq = '0; ec = '0; rs = 1'b0; vmask = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx[i] = 0; acc_cnt[i] = 0;
      end
   endtask

   // one cycle: apply inputs at negedge, sample #1 later, advance sources
   task automatic cyc(input logic b);
      @(negedge clk);
      rst = rs; busy = b; src_req = rq; err_clr = ec;
      for (int i = 0; i < N; i++) begin
         src_valid[i] = vmask[i];
         src_data[i*8 +: 8] = vmask[i] ? pk[i][idx[i]] : 8'h00;
      end
      #1;
      o_grant = grant; o_ready = src_ready; o_perr = proto_err;
      o_pv = pkt_valid; o_done = pkt_done; o_dout = data_out;
      for (int i = 0; i < N; i++) begin
         if (src_ready[i]) begin
            acc_cnt[i]++;
            idx[i]++;
            if (idx[i] >= plen[i]) idx[i] = 0;
         end
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int order[$];
      int idle;
      logic [N-1:0] pg;

      tv[0] = '{3'b010, 3'b000, 24'h000000, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
      tv[1] = '{3'b010, 3'b010, 24'h000D00, 3'b010, 1'b1, 8'h0D, 3'b010, 1'b0};
      tv[2] = '{3'b010, 3'b010, 24'h00A100, 3'b010, 1'b1, 8'hA1, 3'b010, 1'b0};
      tv[3] = '{3'b010, 3'b010, 24'h00A200, 3'b010, 1'b1, 8'hA2, 3'b010, 1'b0};
      tv[4] = '{3'b010, 3'b010, 24'h00A300, 3'b010, 1'b1, 8'hA3, 3'b010, 1'b0};
      tv[5] = '{3'b010, 3'b010, 24'h000F00, 3'b010, 1'b0, 8'h0F, 3'b010, 1'b0};
      tv[6] = '{3'b000, 3'b000, 24'h000000, 3'b000, 1'b0, 8'h00, 3'b000, 1'b1};
      tv[7] = '{3'b000, 3'b000, 24'h000000, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
      tv[8] = '{3'b000, 3'b000, 24'h000000, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};

      do_reset();
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_pv", pkt_valid, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_ready", src_ready, 0);
      chk("rst_perr", proto_err, 0);
      chk("rst_done", pkt_done, 0);

      for (int v = 0; v < 9; v++) begin
         @(negedge clk);
         src_req = tv[v].req; src_valid = tv[v].valid;
         src_data = tv[v].data;
         #1;
         chk($sformatf("tv%0d_grant", v), grant, tv[v].e_grant);
         chk($sformatf("tv%0d_pv", v), pkt_valid, tv[v].e_pv);
         chk($sformatf("tv%0d_dout", v), data_out, tv[v].e_dout);
         chk($sformatf("tv%0d_ready", v), src_ready, tv[v].e_ready);
         chk($sformatf("tv%0d_done", v), pkt_done, tv[v].e_done);
      end

      // busy stall after header
      do_reset();
      pk[0][0] = 8'h08; pk[0][1] = 8'hB1; pk[0][2] = 8'hB2; pk[0][3] = 8'h5A;
      plen[0] = 4; rq = 3'b001; vmask = 3'b001;
      cyc(0); chk("busy_idle_grant", o_grant, 0);
      cyc(0); chk("busy_hdr_ready", o_ready, 3'b001);
      chk("busy_hdr_dout", o_dout, 8'h08);
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         chk("busy_stall_ready", o_ready, 0);
         chk("busy_stall_dout", o_dout, 8'hB1);
      end
      cyc(0); chk("busy_p1", {o_ready, o_dout}, {3'b001, 8'hB1});
      cyc(0); chk("busy_p2", {o_ready, o_dout}, {3'b001, 8'hB2});
      cyc(0); chk("busy_par", {o_pv, o_ready, o_dout}, {1'b0, 3'b001, 8'h5A});
      rq = '0; vmask = '0;
      cyc(0); chk("busy_done", o_done, 1);
      chk("busy_bytes", acc_cnt[0], 4);

      // zero-length packet
      do_reset();
      pk[1][0] = 8'h00; pk[1][1] = 8'h3C; plen[1] = 2;
      rq = 3'b010; vmask = 3'b010;
      cyc(0);
      cyc(0); chk("len0_hdr", {o_pv, o_ready}, {1'b1, 3'b010});
      cyc(0); chk("len0_par", {o_pv, o_ready, o_dout}, {1'b0, 3'b010, 8'h3C});
      rq = '0; vmask = '0;
      cyc(0); chk("len0_done", {o_done, o_grant}, {1'b1, 3'b000});

      // source 2 aborts mid-payload
      do_reset();
      pk[2][0] = 8'h12; pk[2][1] = 8'hC1; pk[2][2] = 8'hC2;
      pk[2][3] = 8'hC3; pk[2][4] = 8'hC4; pk[2][5] = 8'hE5; plen[2] = 6;
      pk[0][0] = 8'h04; pk[0][1] = 8'hD1; pk[0][2] = 8'h77; plen[0] = 3;
      rq = 3'b100; vmask = 3'b100;
      cyc(0); cyc(0);
      cyc(0); chk("ab_c1", {o_ready, o_dout}, {3'b100, 8'hC1});
      rq = 3'b101; vmask = 3'b001;
      cyc(0);
      chk("ab_cycle", {o_pv, o_dout, o_ready, o_grant},
          {1'b0, 8'h00, 3'b000, 3'b100});
      cyc(0); chk("ab_perr", o_perr, 3'b100);
      chk("ab_nodone", o_done, 0);
      cyc(0); cyc(0);
      cyc(0); chk("ab_next_grant", o_grant, 3'b001);
      chk("ab_next_hdr", o_dout, 8'h04);
      cyc(0);
      cyc(0); chk("ab_next_par", {o_pv, o_dout}, {1'b0, 8'h77});
      rq = 3'b100; vmask = 3'b000;
      cyc(0); chk("ab_next_done", o_done, 1);
      cyc(0);
      for (int k = 0; k < 4; k++) begin
         cyc(0); chk("ab_masked", o_grant, 0);
      end
      rq = 3'b000; ec = 3'b100;
      cyc(0);
      ec = 3'b000;
      cyc(0); chk("ab_clr", o_perr, 0);
      rq = 3'b100; vmask = 3'b100; idx[2] = 0;
      cyc(0);
      cyc(0); chk("ab_regrant", {o_grant, o_dout}, {3'b100, 8'h12});

      // reset during payload
      cyc(0);
      pk[1][0] = 8'h04; pk[1][1] = 8'hE1; pk[1][2] = 8'h66; plen[1] = 3;
      idx[0] = 0; idx[1] = 0;
      rs = 1'b1; rq = 3'b011; vmask = 3'b011;
      cyc(0);
      rs = 1'b0;
      cyc(0);
      chk("mr_state", {o_grant, o_pv, o_ready, o_perr, o_done},
          {3'b000, 1'b0, 3'b000, 3'b000, 1'b0});
      cyc(0); chk("mr_first_grant", o_grant, 3'b001);

      // round robin with all sources requesting
      do_reset();
      for (int i = 0; i < N; i++) begin
         pk[i][0] = 8'h08 | 8'(i);
         pk[i][1] = 8'h10 + 8'(i);
         pk[i][2] = 8'h20 + 8'(i);
         pk[i][3] = 8'h30 + 8'(i);
         plen[i] = 4;
      end
      rq = 3'b111; vmask = 3'b111;
      idle = 0; pg = '0;
      for (int c = 0; c < 120 && order.size() < 6; c++) begin
         cyc(0);
         if (o_grant == '0) idle++;
         else if (pg == '0) begin
            if (order.size() > 0)
               chk("rr_gap", (idle >= G) ? 1 : 0, 1);
            order.push_back(oh2i(o_grant));
            idle = 0;
         end
         pg = o_grant;
      end
      chk("rr_count", order.size(), 6);
      for (int i = 0; i < order.size(); i++)
         chk($sformatf("rr_order%0d", i), order[i], i % N);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
